csa_8_arbiter: RTL and testbench
================================

# csa_8_arbiter

Round-robin arbiter and sequencer that shares one `csa_8` 8-bit carry-select adder among `N_REQ` requesters. Each requester presents an operand pair under a valid/ready handshake. The arbiter grants one request per cycle, drives the shared adder and registers the sum, carry and winning requester index. The registered result is presented on a single response channel with backpressure. The block sits between the client units and the adder, so only one `csa_8` instance exists in the design.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester index; derived, not overridden.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  N_REQ  bit i high: requester i presents an operand pair.
- `req_a`  in  8*N_REQ  operand A; requester i uses bits [8i+7:8i].
- `req_b`  in  8*N_REQ  operand B; same packing as `req_a`.
- `req_ready`  out  N_REQ  one-hot grant; bit i high: requester i's pair is accepted this cycle.
- `rsp_valid`  out  1  registered result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_sum`  out  8  a+b mod 256 for the granted pair.
- `rsp_carry`  out  1  carry out of bit 7.
- `rsp_id`  out  ID_W  index of the requester that produced the result.

## Operation
- One internal `csa_8` instance. Its inputs are the operands of the granted requester, muxed combinationally. Its outputs are captured into the response register on the grant cycle.
- **State machine**, two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- **Accept condition:** `can_accept` = (state==EMPTY) OR (state==FULL AND `rsp_ready`).
- **Grant selection**, when `can_accept` and any `req_valid` is high:
  - Grant the first valid index found searching upward from the pointer `rr_ptr`, wrapping from N_REQ-1 to 0.
  - `req_ready` is one-hot on that index, zero elsewhere.
  - `req_ready` is combinational from `req_valid`, `rr_ptr`, state and `rsp_ready`.
- **On a grant:**
  - Capture sum, carry and index into the response register.
  - Set `rr_ptr` to (grant+1) mod N_REQ.
  - Next state is FULL.
- **Transitions:**
  - EMPTY to FULL on a grant.
  - FULL to EMPTY on `rsp_ready` with no grant.
  - FULL to FULL on `rsp_ready` with a grant, loading the new result. This is a back-to-back transfer.
  - FULL to FULL holding on `rsp_ready`=0.
- **FULL with `rsp_ready`=0:**
  - All `req_ready`=0.
  - `rsp_sum`, `rsp_carry` and `rsp_id` stay stable.
  - `rr_ptr` is unchanged.
- **No valid requests:** `rr_ptr` is unchanged and no grant is issued.
- **Requester rules:**
  - `req_a` and `req_b` must be held stable while `req_valid` is high and `req_ready` is low.
  - A requester may drop `req_valid` before it is granted. The arbiter imposes no penalty.
- **Arithmetic:** `{rsp_carry, rsp_sum}` = a + b as a 9-bit result. Carry-in is always 0.
- **Reset, when `rst_n`=0 at a clock edge:**
  - State goes to EMPTY and `rr_ptr` to 0.
  - `rsp_sum`, `rsp_carry` and `rsp_id` go to 0.
  - Any held result is discarded.
  - `req_ready` is forced to 0 while `rst_n` is low.

## Timing
- Latency: a request granted in cycle T has `rsp_valid`=1 with its result in cycle T+1.
- Throughput: one result per cycle while `rsp_ready` stays high and requests are pending.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once in every N_REQ consecutive grants.
- Combinational paths:
  - `req_valid` and `rsp_ready` to `req_ready`.
  - The adder path runs only from the request mux into the response register; no path reaches the response outputs directly.
- Reset values:
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_carry`=0, `rsp_id`=0.
  - `req_ready`=0 during reset.
  - On the first cycle after reset with EMPTY, `req_ready` follows the grant rules.
- Simultaneous events: consumer accept and new grant in the same cycle are legal; the old result retires and the new result loads at the same edge.

## Test plan
- **Single request:** reset; requester 2 drives a=0x7F, b=0x01 with `rsp_ready`=1.
  - `req_ready`=0b0100 in the same cycle.
  - Next cycle: `rsp_valid`=1, `rsp_sum`=0x80, `rsp_carry`=0, `rsp_id`=2.
- **Carry out:** requester 0 drives a=0xFF, b=0x01, then a=0xF0, b=0xF0 back-to-back.
  - First response: `rsp_sum`=0x00, `rsp_carry`=1.
  - Second response: `rsp_sum`=0xE0, `rsp_carry`=1, one cycle later.
- **Round-robin:** all four requesters valid continuously, `rsp_ready`=1 from reset.
  - Grants go to 0,1,2,3,0,1,…
  - `rsp_id` sequence is 0,1,2,3,0 with no idle cycles.
- **Backpressure:** requesters 1 and 3 valid, `rsp_ready` held 0 for 5 cycles after the first grant (to 1).
  - `req_ready` is all zero for those cycles and the response holds id=1 stable.
  - When `rsp_ready` rises: id=1 retires and requester 3 is granted in the same cycle.
- **Pointer skip:** after a grant to 3 (`rr_ptr`=0), only requester 1 is valid.
  - Grant goes to 1 and `rr_ptr` becomes 2.
  - Then requesters 0 and 2 are both valid: grant goes to 2 first.
- **Reset mid-operation:** FULL with `rsp_ready`=0, then assert `rst_n`=0 for one edge.
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0 and `rr_ptr`=0.
  - After release, requester 0 is granted first when all are valid.

Source files
------------

// File: rtl/csa_8_arbiter.sv
// Round-robin arbiter that shares one 8-bit carry-select adder among N_REQ requesters.
// The winning pair is added combinationally and the result is held in a one-entry response register.

module csa_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [3:0] lo_sum, hi_sum0, hi_sum1;
  logic       lo_c, hi_c0, hi_c1;

  function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    logic [4:0] r;
    logic       c;
    // NOTE: blocking '=' is correct here: this is combinational evaluation, each bit needs the carry just computed.
    c = ci;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[4] = c;
    return r;
  endfunction

  // Upper nibble is precomputed for both carry-ins; the low-nibble carry picks one.
  assign {lo_c,  lo_sum}  = ripple4(a[3:0], b[3:0], cin);
  assign {hi_c0, hi_sum0} = ripple4(a[7:4], b[7:4], 1'b0);
  assign {hi_c1, hi_sum1} = ripple4(a[7:4], b[7:4], 1'b1);

  assign sum  = {lo_c ? hi_sum1 : hi_sum0, lo_sum};
  assign cout = lo_c ? hi_c1 : hi_c0;
endmodule

module csa_8_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_sum,
  output logic               rsp_carry,
  output logic [ID_W-1:0]    rsp_id
);
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] ptr_next;
  logic            gnt_found;
  logic            can_accept;
  logic            grant;
  logic [7:0]      op_a, op_b;
  logic [7:0]      add_sum;
  logic            add_carry;
  int              cand;

  // Search upward from rr_ptr, wrapping at N_REQ-1, for the first valid requester.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  assign ptr_next   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign can_accept = (state == S_EMPTY) || rsp_ready;
  assign grant      = rst_n && can_accept && gnt_found;
  assign req_ready  = grant ? (N_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        op_a = req_a[8*i +: 8];
        op_b = req_b[8*i +: 8];
      end
    end
  end

  csa_8 u_csa_8 (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_carry)
  );

  assign rsp_valid = (state == S_FULL);

  // A grant while FULL retires the old result and loads the new one at the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
    if (!rst_n) begin
      state     <= S_EMPTY;
      rr_ptr    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else if (grant) begin
      state     <= S_FULL;
      rr_ptr    <= ptr_next;
      rsp_sum   <= add_sum;
      rsp_carry <= add_carry;
      rsp_id    <= gnt_idx;
    end else if (state == S_FULL && rsp_ready) begin
      state <= S_EMPTY;
    end
  end
endmodule

// File: tb/tb_csa_8_arbiter.sv
// Self-checking bench for csa_8_arbiter: directed steps plus a random phase, with a reference
// arbiter model feeding a scoreboard of expected responses.

module tb_csa_8_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_a, req_b;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_sum;
  logic             rsp_carry;
  logic [ID_W-1:0]  rsp_id;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int         id;
    logic [8:0] res;
  } exp_t;

  exp_t sb[$];

  csa_8_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Reference model, evaluated mid-cycle while inputs and DUT outputs are stable.
  logic         m_init = 1'b0;
  logic         m_full;
  logic         m_zero;
  int           m_ptr;
  int           m_g;
  logic [N-1:0] m_exp_ready;
  logic [N-1:0] m_gnt_vec = '0;
  logic [8:0]   m_res;
  exp_t         m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("ready_in_reset", 32'(req_ready), 32'h0);
    end
    if (m_init) begin
      check("rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full) begin
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          check("rsp_sum",   32'(rsp_sum),   32'(sb[0].res[7:0]));
          check("rsp_carry", 32'(rsp_carry), 32'(sb[0].res[8]));
          check("rsp_id",    32'(rsp_id),    32'(sb[0].id));
        end
      end
      if (m_zero) begin
        check("rsp_sum_reset", 32'(rsp_sum),   32'h0);
        check("rsp_carry_reset", 32'(rsp_carry), 32'h0);
        check("rsp_id_reset",  32'(rsp_id),    32'h0);
      end
      m_g = (rst_n && (!m_full || rsp_ready)) ? model_grant(req_valid, m_ptr) : -1;
      m_exp_ready = (m_g >= 0) ? N'(1) << m_g : '0;
      if (rst_n) check("req_ready", 32'(req_ready), 32'(m_exp_ready));
    end else begin
      m_g = -1;
      m_exp_ready = '0;
    end
    m_gnt_vec = m_exp_ready;

    if (!rst_n) begin
      m_init = 1'b1;
      m_full = 1'b0;
      m_zero = 1'b1;
      m_ptr  = 0;
      sb.delete();
    end else if (m_init) begin
      if (m_full && rsp_ready && sb.size() > 0) void'(sb.pop_front());
      if (m_g >= 0) begin
        m_res   = {1'b0, req_a[8*m_g +: 8]} + {1'b0, req_b[8*m_g +: 8]};
        m_e.id  = m_g;
        m_e.res = m_res;
        sb.push_back(m_e);
        m_ptr  = (m_g + 1) % N;
        m_full = 1'b1;
        m_zero = 1'b0;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    // Single request from requester 2.
    req_valid = 4'b0100;
    set_op(2, 8'h7F, 8'h01);
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    @(negedge clk);
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_sum",   32'(rsp_sum),   32'h80);
    check("single_carry", 32'(rsp_carry), 32'd0);
    check("single_id",    32'(rsp_id),    32'd2);
    step();

    // Carry out, back-to-back from requester 0.
    req_valid = 4'b0001;
    set_op(0, 8'hFF, 8'h01);
    @(negedge clk);
    check("carry_ready0", 32'(req_ready), 32'b0001);
    step();
    set_op(0, 8'hF0, 8'hF0);
    @(negedge clk);
    check("carry_ready1", 32'(req_ready), 32'b0001);
    check("carry_sum0",   32'(rsp_sum),   32'h00);
    check("carry_c0",     32'(rsp_carry), 32'd1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("carry_sum1", 32'(rsp_sum),   32'hE0);
    check("carry_c1",   32'(rsp_carry), 32'd1);
    step();

    // Round-robin with all requesters valid from reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_op(i, 8'(8'h10 * i + 1), 8'(8'h21 + i));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_ready", 32'(req_ready), 32'(1 << (k % N)));
      if (k > 0) begin
        check("rr_valid", 32'(rsp_valid), 32'd1);
        check("rr_id",    32'(rsp_id),    32'((k - 1) % N));
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    check("rr_last_id", 32'(rsp_id), 32'd3);
    step();

    // Backpressure: grant to 1, hold for five cycles, then retire and grant 3 together.
    req_valid = 4'b1010;
    set_op(1, 8'h11, 8'h22);
    set_op(3, 8'h80, 8'h90);
    @(negedge clk);
    check("bp_ready_first", 32'(req_ready), 32'b0010);
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready_hold", 32'(req_ready), 32'h0);
      check("bp_id_hold",    32'(rsp_id),    32'd1);
      check("bp_sum_hold",   32'(rsp_sum),   32'h33);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_release", 32'(req_ready), 32'b1000);
    check("bp_id_release",    32'(rsp_id),    32'd1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("bp_id_next",  32'(rsp_id),    32'd3);
    check("bp_sum_next", 32'(rsp_sum),   32'h10);
    check("bp_c_next",   32'(rsp_carry), 32'd1);
    step();

    // Pointer skip after the grant to 3.
    req_valid = 4'b0010;
    @(negedge clk);
    check("skip_ready1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0101;
    @(negedge clk);
    check("skip_ready2", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0001;
    @(negedge clk);
    check("skip_ready0", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();

    // Reset while FULL and stalled.
    req_valid = 4'b0001;
    set_op(0, 8'h5A, 8'h5A);
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    check("mid_full", 32'(rsp_valid), 32'd1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_ready_rst", 32'(req_ready), 32'h0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("mid_valid", 32'(rsp_valid), 32'd0);
    check("mid_sum",   32'(rsp_sum),   32'h0);
    check("mid_id",    32'(rsp_id),    32'd0);
    check("mid_ready", 32'(req_ready), 32'b0001);
    step();
    step();
    req_valid = '0;
    step();
    step();

    // Random traffic; operands held while a requester waits for its grant.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_gnt_vec[i]) begin
          set_op(i, 8'($urandom), 8'($urandom));
          req_valid[i] = ($urandom_range(0, 9) < 6);
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
